// File: rtl/dbg_apb_pkg.sv
// -----------------------------------------------------------------------------
// dbg_apb_pkg
//   Shared types and default widths for the debug APB initiator.
//   - dbg_apb_state_e : transfer FSM states (IDLE -> SETUP -> ACCESS -> RESP)
//   - dbg_apb_req_t   : latched host command (direction, address, write data)
//   - DBG_APB_*       : default parameter values used by the interfaces and top
// No ports (package).
// -----------------------------------------------------------------------------
package dbg_apb_pkg;

    localparam int DBG_APB_ADDR_W      = 5;
    localparam int DBG_APB_WDATA_W     = 32;
    localparam int DBG_APB_RDATA_W     = 32;
    localparam int DBG_APB_TIMEOUT_DEF = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } dbg_apb_state_e;

    // The command register is sized at the default widths; the top rejects
    // wider parameterisations at elaboration.
    typedef struct packed {
        logic                       wr_rd;
        logic [DBG_APB_ADDR_W-1:0]  addr;
        logic [DBG_APB_WDATA_W-1:0] wdata;
    } dbg_apb_req_t;

endpackage

// File: rtl/dbg_apb_if.sv
// -----------------------------------------------------------------------------
// dbg_host_if / dbg_apb_if
//   dbg_host_if : host-side command/response channel.
//     req_valid/req_ready/req_wr_rd/req_addr/req_wdata  host -> initiator
//     rsp_valid/rsp_ready/rsp_rdata/rsp_err             initiator -> host
//     modport master = host bridge, modport slave = dbg_apb_master.
//   dbg_apb_if  : APB bus toward a core's debug slave.
//     apb_addr/apb_sel/apb_enable/apb_wr_rd/apb_wdata    initiator -> slave
//     apb_ready/apb_rdata                                slave -> initiator
//     modport master = dbg_apb_master, modport slave = debug register slave.
// -----------------------------------------------------------------------------
interface dbg_host_if
    import dbg_apb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH  = DBG_APB_ADDR_W,
    parameter int APB_WDATA_WIDTH = DBG_APB_WDATA_W,
    parameter int APB_RDATA_WIDTH = DBG_APB_RDATA_W
);
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_wr_rd;
    logic [APB_ADDR_WIDTH-1:0]  req_addr;
    logic [APB_WDATA_WIDTH-1:0] req_wdata;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [APB_RDATA_WIDTH-1:0] rsp_rdata;
    logic                       rsp_err;

    modport master (
        output req_valid, req_wr_rd, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wr_rd, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

interface dbg_apb_if
    import dbg_apb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH  = DBG_APB_ADDR_W,
    parameter int APB_WDATA_WIDTH = DBG_APB_WDATA_W,
    parameter int APB_RDATA_WIDTH = DBG_APB_RDATA_W
);
    logic [APB_ADDR_WIDTH-1:0]  apb_addr;
    logic                       apb_sel;
    logic                       apb_enable;
    logic                       apb_wr_rd;
    logic [APB_WDATA_WIDTH-1:0] apb_wdata;
    logic                       apb_ready;
    logic [APB_RDATA_WIDTH-1:0] apb_rdata;

    modport master (
        output apb_addr, apb_sel, apb_enable, apb_wr_rd, apb_wdata,
        input  apb_ready, apb_rdata
    );

    modport slave (
        input  apb_addr, apb_sel, apb_enable, apb_wr_rd, apb_wdata,
        output apb_ready, apb_rdata
    );
endinterface

// File: rtl/dbg_apb_wdog.sv
// -----------------------------------------------------------------------------
// dbg_apb_wdog
//   Saturating ACCESS wait counter for the debug APB initiator. Only used when
//   DBG_APB_TIMEOUT_EN is defined.
//   Ports:
//     clk       in   clock
//     rst_n     in   synchronous reset, active low (clears the count)
//     clr_i     in   clear the count (asserted whenever the FSM is not in ACCESS)
//     inc_i     in   count one ready-low ACCESS cycle
//     expire_o  out  count has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module dbg_apb_wdog
    import dbg_apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DBG_APB_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);
    localparam int            CW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturates at LIMIT so a held expire never wraps back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LIMIT);

endmodule

// File: rtl/dbg_apb_master.sv
// -----------------------------------------------------------------------------
// dbg_apb_master
//   APB initiator for the core debug port. Accepts one register read/write
//   command from the host bridge, runs one APB transfer (SETUP then ACCESS,
//   extended while apb_ready is low) and returns one response.
//   Ports:
//     clk    in      clock
//     rst_n  in      synchronous reset, active low; aborts any transfer
//     host   slave   dbg_host_if: req_valid/req_ready/req_wr_rd/req_addr/
//                    req_wdata, rsp_valid/rsp_ready/rsp_rdata/rsp_err
//     apb    master  dbg_apb_if: apb_addr/apb_sel/apb_enable/apb_wr_rd/
//                    apb_wdata, apb_ready/apb_rdata
//   Configuration macro: DBG_APB_TIMEOUT_EN
//     defined   : ACCESS aborts after TIMEOUT_CYCLES ready-low cycles, rsp_err=1
//     undefined : ACCESS waits forever, rsp_err tied 0
// -----------------------------------------------------------------------------
module dbg_apb_master
    import dbg_apb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH  = DBG_APB_ADDR_W,
    parameter int APB_WDATA_WIDTH = DBG_APB_WDATA_W,
    parameter int APB_RDATA_WIDTH = DBG_APB_RDATA_W,
    parameter int TIMEOUT_CYCLES  = DBG_APB_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    dbg_host_if.slave  host,
    dbg_apb_if.master  apb
);
    // The latched command uses the package struct, so wider buses cannot fit.
    if ((APB_ADDR_WIDTH > DBG_APB_ADDR_W) || (APB_WDATA_WIDTH > DBG_APB_WDATA_W)) begin : g_width_chk
        $error("dbg_apb_master: address/wdata width exceeds dbg_apb_req_t");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_chk
        $error("dbg_apb_master: TIMEOUT_CYCLES must be >= 2");
    end

    dbg_apb_state_e             state_q, state_d;
    dbg_apb_req_t               req_q, req_d;
    logic [APB_RDATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                       accept;
    logic                       apb_done;
    logic                       timeout;

    assign accept   = (state_q == IDLE) && host.req_valid;
    assign apb_done = (state_q == ACCESS) && apb.apb_ready;

`ifdef DBG_APB_TIMEOUT_EN
    logic err_q, err_d;
    logic wd_expire;

    dbg_apb_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (state_q != ACCESS),
        .inc_i    ((state_q == ACCESS) && !apb.apb_ready),
        .expire_o (wd_expire)
    );

    // A ready on the expiry cycle completes normally; only a still-low ready aborts.
    assign timeout = (state_q == ACCESS) && !apb.apb_ready && wd_expire;
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (host.req_valid)            state_d = SETUP;
            SETUP:                                  state_d = ACCESS;
            ACCESS:  if (apb.apb_ready || timeout)  state_d = RESP;
            RESP:    if (host.rsp_ready)            state_d = IDLE;
            default:                                state_d = IDLE;
        endcase
    end

    // Command and response holding registers. They carry no reset: every
    // output that exposes them is gated by the FSM state, which is reset.
    always_comb begin
        req_d   = req_q;
        rdata_d = rdata_q;
`ifdef DBG_APB_TIMEOUT_EN
        err_d   = err_q;
`endif
        if (accept) begin
            req_d.wr_rd = host.req_wr_rd;
            req_d.addr  = DBG_APB_ADDR_W'(host.req_addr);
            req_d.wdata = DBG_APB_WDATA_W'(host.req_wdata);
        end
        if (apb_done) begin
            rdata_d = req_q.wr_rd ? '0 : apb.apb_rdata;
`ifdef DBG_APB_TIMEOUT_EN
            err_d   = 1'b0;
`endif
        end else if (timeout) begin
            rdata_d = '0;
`ifdef DBG_APB_TIMEOUT_EN
            err_d   = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        req_q   <= req_d;
        rdata_q <= rdata_d;
`ifdef DBG_APB_TIMEOUT_EN
        err_q   <= err_d;
`endif
    end

    // Output decode from the current state
    always_comb begin
        host.req_ready = 1'b0;
        host.rsp_valid = 1'b0;
        host.rsp_rdata = '0;
        host.rsp_err   = 1'b0;
        apb.apb_sel    = 1'b0;
        apb.apb_enable = 1'b0;
        apb.apb_addr   = '0;
        apb.apb_wr_rd  = 1'b0;
        apb.apb_wdata  = '0;
        unique case (state_q)
            IDLE: begin
                host.req_ready = 1'b1;
            end
            SETUP, ACCESS: begin
                apb.apb_sel    = 1'b1;
                apb.apb_enable = (state_q == ACCESS);
                apb.apb_addr   = APB_ADDR_WIDTH'(req_q.addr);
                apb.apb_wr_rd  = req_q.wr_rd;
                // Write data is meaningless on reads; keep the bus quiet.
                apb.apb_wdata  = req_q.wr_rd ? APB_WDATA_WIDTH'(req_q.wdata) : '0;
            end
            RESP: begin
                host.rsp_valid = 1'b1;
                host.rsp_rdata = rdata_q;
`ifdef DBG_APB_TIMEOUT_EN
                host.rsp_err   = err_q;
`endif
            end
            default: begin
                host.req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dbg_apb_master.sv
// -----------------------------------------------------------------------------
// tb_dbg_apb_master
//   Bench for dbg_apb_master. A register-file slave with programmable wait
//   states and an APB protocol monitor run on the falling edge; the scenarios
//   drive the host side and compare against a 32-entry register model.
// -----------------------------------------------------------------------------
module tb_dbg_apb_master;
    localparam int AW = 5;
    localparam int WW = 32;
    localparam int RW = 32;
    localparam int TO = 8;
`ifdef DBG_APB_TIMEOUT_EN
    localparam bit ABORT_OK = 1'b1;
`else
    localparam bit ABORT_OK = 1'b0;
`endif

    logic clk;
    logic rst_n;

    dbg_host_if #(.APB_ADDR_WIDTH(AW), .APB_WDATA_WIDTH(WW), .APB_RDATA_WIDTH(RW)) host ();
    dbg_apb_if  #(.APB_ADDR_WIDTH(AW), .APB_WDATA_WIDTH(WW), .APB_RDATA_WIDTH(RW)) apb ();

    dbg_apb_master #(
        .APB_ADDR_WIDTH (AW),
        .APB_WDATA_WIDTH(WW),
        .APB_RDATA_WIDTH(RW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .host (host),
        .apb  (apb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [RW-1:0] ref_regs [32];   // expected register contents
    logic [RW-1:0] slv_mem  [32];   // slave's storage, written over APB
    int  slv_wait = 0;
    int  wait_cnt = 0;
    int  viol     = 0;
    bit  p_sel, p_en, p_rdy, pp_sel, p_rst_n, p_wr;
    logic [AW-1:0] p_addr;
    logic [WW-1:0] p_wdata;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Slave responder and protocol monitor, evaluated mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (apb.apb_enable === 1'b1 && apb.apb_sel !== 1'b1) viol++;
            if (p_rst_n) begin
                if (p_sel && !(p_en && p_rdy)) begin
                    if (apb.apb_sel === 1'b1 && apb.apb_enable === 1'b1) begin
                        if (apb.apb_addr !== p_addr || apb.apb_wr_rd !== p_wr || apb.apb_wdata !== p_wdata) viol++;
                    end else if (!(ABORT_OK && p_en)) begin
                        viol++;
                    end
                end
                if (p_sel && p_en && p_rdy && apb.apb_sel === 1'b1) viol++;
                if (apb.apb_sel === 1'b1 && !p_sel && (apb.apb_enable === 1'b1 || pp_sel)) viol++;
            end
            pp_sel  = p_sel;
            p_sel   = (apb.apb_sel === 1'b1);
            p_en    = (apb.apb_enable === 1'b1);
            p_addr  = apb.apb_addr;
            p_wr    = (apb.apb_wr_rd === 1'b1);
            p_wdata = apb.apb_wdata;
            p_rst_n = (rst_n === 1'b1);

            if (apb.apb_sel === 1'b1 && apb.apb_enable === 1'b1) begin
                if (wait_cnt < slv_wait) begin
                    apb.apb_ready = 1'b0;
                    apb.apb_rdata = $urandom;
                    wait_cnt++;
                end else begin
                    apb.apb_ready = 1'b1;
                    wait_cnt      = 0;
                    if (apb.apb_wr_rd === 1'b1) begin
                        apb.apb_rdata = $urandom;
                        slv_mem[apb.apb_addr] = apb.apb_wdata;
                    end else begin
                        apb.apb_rdata = slv_mem[apb.apb_addr];
                    end
                end
            end else begin
                // Ready toggles freely outside ACCESS; the initiator must ignore it.
                apb.apb_ready = 1'($urandom_range(0, 1));
                apb.apb_rdata = $urandom;
                wait_cnt      = 0;
            end
            p_rdy = (apb.apb_ready === 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [WW-1:0] d, output bit ok);
        int n;
        n = 0;
        host.req_valid = 1'b1;
        host.req_wr_rd = wr;
        host.req_addr  = a;
        host.req_wdata = d;
        while (host.req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        ok = (host.req_ready === 1'b1);
        tick();
        host.req_valid = 1'b0;
        host.req_wr_rd = 1'($urandom_range(0, 1));
        host.req_addr  = AW'($urandom);
        host.req_wdata = $urandom;
    endtask

    // Called right after the accept edge; lat counts cycles from the accept cycle.
    task automatic wait_rsp(input int budget, output bit ok, output int lat,
                            output logic [RW-1:0] rd, output logic er);
        lat = 1;
        while (host.rsp_valid !== 1'b1 && lat < budget) begin
            tick();
            lat++;
        end
        ok = (host.rsp_valid === 1'b1);
        rd = host.rsp_rdata;
        er = host.rsp_err;
    endtask

    task automatic ack();
        host.rsp_ready = 1'b1;
        tick();
        host.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (host.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_req_ready: got %b expected 1", host.req_ready);
        end
        n_checks++;
        if ({host.rsp_valid, host.rsp_err, apb.apb_sel, apb.apb_enable, apb.apb_wr_rd} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 00000",
                {host.rsp_valid, host.rsp_err, apb.apb_sel, apb.apb_enable, apb.apb_wr_rd});
        end
        n_checks++;
        if (host.rsp_rdata !== '0 || apb.apb_wdata !== '0 || apb.apb_addr !== '0) begin
            n_fail++; $display("FAIL reset_data: rdata=%h wdata=%h addr=%h expected all 0",
                host.rsp_rdata, apb.apb_wdata, apb.apb_addr);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (host.req_ready !== 1'b1 || apb.apb_sel !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: req_ready=%b sel=%b expected 1/0", host.req_ready, apb.apb_sel);
        end
    endtask

    task automatic test_write_nowait();
        slv_wait = 0;
        host.req_valid = 1'b1; host.req_wr_rd = 1'b1; host.req_addr = 5'h03; host.req_wdata = 32'hDEADBEEF;
        tick();
        host.req_valid = 1'b0; host.req_addr = 5'h1C; host.req_wdata = 32'h0BAD0BAD; host.req_wr_rd = 1'b0;
        ref_regs[3] = 32'hDEADBEEF;
        n_checks++;
        if ({apb.apb_sel, apb.apb_enable, apb.apb_wr_rd} !== 3'b101 || apb.apb_addr !== 5'h03 || apb.apb_wdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL wr_setup: sel/en/wr=%b addr=%h wdata=%h expected 101 03 deadbeef",
                {apb.apb_sel, apb.apb_enable, apb.apb_wr_rd}, apb.apb_addr, apb.apb_wdata);
        end
        tick();
        n_checks++;
        if ({apb.apb_sel, apb.apb_enable} !== 2'b11 || apb.apb_addr !== 5'h03 || apb.apb_wdata !== 32'hDEADBEEF || host.rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL wr_access: sel/en=%b addr=%h wdata=%h rsp_valid=%b expected 11 03 deadbeef 0",
                {apb.apb_sel, apb.apb_enable}, apb.apb_addr, apb.apb_wdata, host.rsp_valid);
        end
        tick();
        n_checks++;
        if (host.rsp_valid !== 1'b1 || {apb.apb_sel, apb.apb_enable} !== 2'b00) begin
            n_fail++; $display("FAIL wr_latency: rsp_valid=%b sel/en=%b at cycle 3, expected 1 00",
                host.rsp_valid, {apb.apb_sel, apb.apb_enable});
        end
        n_checks++;
        if (host.rsp_rdata !== '0 || host.rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL wr_rsp: rdata=%h err=%b expected 0 0", host.rsp_rdata, host.rsp_err);
        end
        ack();
        n_checks++;
        if (host.rsp_valid !== 1'b0 || host.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL wr_done: rsp_valid=%b req_ready=%b expected 0 1", host.rsp_valid, host.req_ready);
        end
    endtask

    task automatic test_read_wait();
        bit ok; int lat; int en_cnt; bit bad; logic [RW-1:0] rd; logic er;
        slv_wait = 4; en_cnt = 0; bad = 0;
        issue(1'b0, 5'h03, 32'h12345678, ok);
        n_checks++;
        if (apb.apb_wdata !== '0 || apb.apb_wr_rd !== 1'b0) begin
            n_fail++; $display("FAIL rd_wdata_zero: wdata=%h wr=%b expected 0 0", apb.apb_wdata, apb.apb_wr_rd);
        end
        lat = 1;
        while (host.rsp_valid !== 1'b1 && lat < 40) begin
            if (apb.apb_enable === 1'b1) begin
                en_cnt++;
                if (apb.apb_addr !== 5'h03) bad = 1'b1;
            end
            tick();
            lat++;
        end
        rd = host.rsp_rdata; er = host.rsp_err;
        n_checks++;
        if (!ok || en_cnt != 5 || bad) begin
            n_fail++; $display("FAIL rd_enable: accepted=%0d enable_cycles=%0d addr_unstable=%0d expected 1 5 0", ok, en_cnt, bad);
        end
        n_checks++;
        if (lat != 7) begin
            n_fail++; $display("FAIL rd_latency: got %0d expected 7", lat);
        end
        n_checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            n_fail++; $display("FAIL rd_data: got %h err=%b expected deadbeef 0", rd, er);
        end
        if (host.rsp_valid === 1'b1) ack();
    endtask

    task automatic test_rsp_stall();
        bit ok, ok2; int lat; int bad; logic [RW-1:0] rd; logic er;
        logic [AW-1:0] a, b; logic [WW-1:0] w;
        a = AW'($urandom); b = a + 5'd7; w = $urandom; bad = 0;
        slv_wait = 1;
        issue(1'b0, a, 32'h0, ok);
        wait_rsp(40, ok2, lat, rd, er);
        n_checks++;
        if (!(ok && ok2) || rd !== ref_regs[a]) begin
            n_fail++; $display("FAIL stall_first: ok=%0d rdata=%h expected 1 %h", ok && ok2, rd, ref_regs[a]);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                host.req_valid = 1'b1; host.req_wr_rd = 1'b1; host.req_addr = b; host.req_wdata = w;
            end
            if (host.rsp_valid !== 1'b1 || host.rsp_rdata !== rd || host.req_ready !== 1'b0 || apb.apb_sel !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL stall_hold: %0d unstable cycles expected 0", bad);
        end
        ack();
        n_checks++;
        if (host.req_ready !== 1'b1 || host.rsp_valid !== 1'b0 || apb.apb_sel !== 1'b0) begin
            n_fail++; $display("FAIL stall_idle: req_ready=%b rsp_valid=%b sel=%b expected 1 0 0",
                host.req_ready, host.rsp_valid, apb.apb_sel);
        end
        tick();
        host.req_valid = 1'b0;
        ref_regs[b] = w;
        n_checks++;
        if ({apb.apb_sel, apb.apb_enable, apb.apb_wr_rd} !== 3'b101 || apb.apb_addr !== b) begin
            n_fail++; $display("FAIL stall_second: sel/en/wr=%b addr=%h expected 101 %h",
                {apb.apb_sel, apb.apb_enable, apb.apb_wr_rd}, apb.apb_addr, b);
        end
        wait_rsp(40, ok, lat, rd, er);
        n_checks++;
        if (!ok || rd !== '0) begin
            n_fail++; $display("FAIL stall_second_rsp: ok=%0d rdata=%h expected 1 0", ok, rd);
        end
        if (ok) ack();
    endtask

    task automatic test_reset_mid();
        bit ok, ok2; int lat; int bad; logic [RW-1:0] rd; logic er; logic [WW-1:0] w;
        slv_wait = 3; bad = 0;
        issue(1'b0, 5'h03, 32'h0, ok);
        tick();
        n_checks++;
        if (!ok || apb.apb_enable !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_access: ok=%0d enable=%b expected 1 1", ok, apb.apb_enable);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if ({apb.apb_sel, apb.apb_enable, host.rsp_valid, host.req_ready} !== 4'b0001) begin
            n_fail++; $display("FAIL rstmid_abort: sel/en/rsp_valid/req_ready=%b expected 0001",
                {apb.apb_sel, apb.apb_enable, host.rsp_valid, host.req_ready});
        end
        for (int i = 0; i < 6; i++) begin
            if (host.rsp_valid !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL rstmid_no_rsp: %0d response cycles expected 0", bad);
        end
        w = $urandom;
        issue(1'b1, 5'h0A, w, ok);
        wait_rsp(40, ok2, lat, rd, er);
        if (ok2) ack();
        ref_regs[10] = w;
        issue(1'b0, 5'h0A, 32'h0, ok);
        wait_rsp(40, ok2, lat, rd, er);
        n_checks++;
        if (!(ok && ok2) || rd !== ref_regs[10] || lat != 6) begin
            n_fail++; $display("FAIL rstmid_recover: ok=%0d rdata=%h lat=%0d expected 1 %h 6", ok && ok2, rd, lat, ref_regs[10]);
        end
        if (ok2) ack();
    endtask

    task automatic test_timeout();
        bit ok, ok2; int lat; logic [RW-1:0] rd; logic er;
`ifdef DBG_APB_TIMEOUT_EN
        slv_wait = 1000000;
        issue(1'b0, 5'h05, 32'h0, ok);
        wait_rsp(60, ok2, lat, rd, er);
        n_checks++;
        if (!(ok && ok2) || lat != TO + 2) begin
            n_fail++; $display("FAIL timeout_latency: ok=%0d lat=%0d expected 1 %0d", ok && ok2, lat, TO + 2);
        end
        n_checks++;
        if (er !== 1'b1 || rd !== '0) begin
            n_fail++; $display("FAIL timeout_rsp: err=%b rdata=%h expected 1 0", er, rd);
        end
        if (ok2) ack();
        slv_wait = TO - 1;
        issue(1'b0, 5'h05, 32'h0, ok);
        wait_rsp(60, ok2, lat, rd, er);
        n_checks++;
        if (!(ok && ok2) || er !== 1'b0 || rd !== ref_regs[5] || lat != TO + 2) begin
            n_fail++; $display("FAIL timeout_ready_wins: ok=%0d err=%b rdata=%h lat=%0d expected 1 0 %h %0d",
                ok && ok2, er, rd, lat, ref_regs[5], TO + 2);
        end
        if (ok2) ack();
`else
        int bad;
        bad = 0;
        slv_wait = 1000000;
        issue(1'b0, 5'h05, 32'h0, ok);
        tick();
        for (int i = 0; i < 300; i++) begin
            if (host.rsp_valid !== 1'b0 || apb.apb_sel !== 1'b1 || apb.apb_enable !== 1'b1) bad++;
            tick();
        end
        n_checks++;
        if (!ok || bad != 0) begin
            n_fail++; $display("FAIL stuck_wait: ok=%0d bad_cycles=%0d expected 1 0", ok, bad);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (host.req_ready !== 1'b1 || apb.apb_sel !== 1'b0 || host.rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL stuck_recover: req_ready=%b sel=%b err=%b expected 1 0 0",
                host.req_ready, apb.apb_sel, host.rsp_err);
        end
        tick();
        ok2 = 1'b0; lat = 0; rd = '0; er = 1'b0;
`endif
    endtask

    task automatic test_back_to_back();
        bit ok, ok2, wr, early; int lat, w; logic [RW-1:0] rd, exp; logic er;
        logic [AW-1:0] a, last_wa; logic [WW-1:0] d;
        last_wa = '0;
        for (int i = 0; i < 16; i++) begin
            wr    = 1'($urandom_range(0, 1));
            a     = AW'($urandom_range(0, 31));
            d     = $urandom;
            w     = $urandom_range(0, 3);
            early = 1'($urandom_range(0, 1));
            if (i % 4 == 0) wr = 1'b1;
            if (i % 4 == 1) begin wr = 1'b0; a = last_wa; end
            if (wr) last_wa = a;
            exp = wr ? '0 : ref_regs[a];
            if (wr) ref_regs[a] = d;
            slv_wait = w;
            host.rsp_ready = early;
            issue(wr, a, d, ok);
            wait_rsp(40, ok2, lat, rd, er);
            n_checks++;
            if (!(ok && ok2) || rd !== exp || er !== 1'b0) begin
                n_fail++; $display("FAIL b2b_%0d: ok=%0d wr=%0d addr=%h rdata=%h err=%b expected 1 %h 0",
                    i, ok && ok2, wr, a, rd, er, exp);
            end
            n_checks++;
            if (lat != 3 + w) begin
                n_fail++; $display("FAIL b2b_lat_%0d: got %0d expected %0d", i, lat, 3 + w);
            end
            if (early) begin
                tick();
                host.rsp_ready = 1'b0;
                n_checks++;
                if (host.rsp_valid !== 1'b0 || host.req_ready !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_one_cycle_resp_%0d: rsp_valid=%b req_ready=%b expected 0 1",
                        i, host.rsp_valid, host.req_ready);
                end
            end else if (ok2) begin
                ack();
            end
        end
        tick();
        n_checks++;
        if (viol != 0) begin
            n_fail++; $display("FAIL apb_protocol: %0d violations expected 0", viol);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        host.req_valid = 1'b0;
        host.req_wr_rd = 1'b0;
        host.req_addr  = '0;
        host.req_wdata = '0;
        host.rsp_ready = 1'b0;
        apb.apb_ready  = 1'b0;
        apb.apb_rdata  = '0;
        for (int i = 0; i < 32; i++) begin
            ref_regs[i] = $urandom;
            slv_mem[i]  = ref_regs[i];
        end
        test_reset();
        test_write_nowait();
        test_read_wait();
        test_rsp_stall();
        test_reset_mid();
        test_timeout();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
